// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the Montgomery multiplier slice.
//   state_t        : controller states (IDLE, RUN, DONE)
//   internal_width : carry-save datapath width for a given operand width
//   counter_width  : iteration counter width for a given operand width
// ---------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The redundant accumulators carry two guard bits on top of the operand
  // width.  The sum S+C stays below 2N, and each vector stays below 2^(W-1).
  function automatic int internal_width(input int data_width);
    return data_width + 2;
  endfunction

  // The counter must be able to hold DATA_WIDTH, the value it has after the
  // final iteration.
  function automatic int counter_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// ---------------------------------------------------------------------------
// csa_3to2
// Combinational 3:2 carry-save compressor.  x + y + z == sum + carry.
// Parameters:
//   WIDTH  width of the three input vectors
// Ports:
//   x, y, z  in   WIDTH    addends
//   sum      out  WIDTH    bitwise sum (x ^ y ^ z)
//   carry    out  WIDTH+1  majority vector shifted up by one bit
// ---------------------------------------------------------------------------
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH:0]   carry
);

  // Every bit position is compressed independently.  The carry vector is
  // one bit wider so that no carry out of the top bit is ever lost.
  always_comb begin
    sum   = x ^ y ^ z;
    carry = {((x & y) | (x & z) | (y & z)), 1'b0};
  end

endmodule

// File: rtl/mont_csa_multiplier.sv
// ---------------------------------------------------------------------------
// mont_csa_multiplier
// Radix-2 Montgomery multiplier with carry-save accumulation.  Computes
// A*B*2^-DATA_WIDTH mod N, leaving the result in redundant form (s0_r, s1_r)
// with s0_r + s1_r < 2N.  One iteration is performed per enabled clock.
// The downstream final_adder (DATA_WIDTH+1 wide) is kicked off by
// start_final_addition.
//
// Build option:
//   MONT_OUT_REG_EN  when defined, s0_r/s1_r are dedicated registers loaded
//                    only when a result completes.  They hold the previous
//                    result while the next multiplication runs.  When
//                    undefined, s0_r/s1_r are direct views of the
//                    accumulators.
//
// Parameters:
//   DATA_WIDTH  operand/modulus width, also the iteration count
// Ports:
//   clk                   in   1             clock, rising edge
//   rst                   in   1             asynchronous active-high reset
//   ce                    in   1             clock enable, low freezes all state
//   start                 in   1             begin a multiplication (IDLE only)
//   a, b                  in   DATA_WIDTH    operands, each less than n
//   n                     in   DATA_WIDTH    odd modulus
//   busy                  out  1             high whenever not IDLE
//   s0_r                  out  DATA_WIDTH+1  carry-save sum vector
//   s1_r                  out  DATA_WIDTH+1  carry-save carry vector
//   start_final_addition  out  1             high while in DONE
// ---------------------------------------------------------------------------
module mont_csa_multiplier
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  busy,
  output logic [DATA_WIDTH:0]   s0_r,
  output logic [DATA_WIDTH:0]   s1_r,
  output logic                  start_final_addition
);

  localparam int W  = internal_width(DATA_WIDTH);
  localparam int CW = counter_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          s_q;
  logic [W-1:0]          c_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] n_q;

  logic                  a_bit;
  logic                  q;
  logic                  last_iter;
  logic [W-1:0]          addend_b;
  logic [W-1:0]          s1;
  logic [W:0]            c1;
  logic [W:0]            addend_n;
  logic [W:0]            s2;
  logic [W+1:0]          c2;
  logic [W-1:0]          s_next;
  logic [W-1:0]          c_next;
  logic                  unused_bits;

  // Datapath for one iteration: add a_i*B into the redundant accumulator,
  // then add q*N where q makes the sum even, so the halving is exact.
  // Bit 0 of c1 is always 0, so q only depends on the sum vector.
  always_comb begin
    a_bit     = |(a_q & (DATA_WIDTH'(1) << cnt));
    addend_b  = a_bit ? {{(W - DATA_WIDTH){1'b0}}, b_q} : '0;
    q         = s1[0];
    addend_n  = q ? {{(W + 1 - DATA_WIDTH){1'b0}}, n_q} : '0;
    s_next    = s2[W:1];
    c_next    = c2[W:1];
    last_iter = (cnt == LAST_ITER);
  end

  csa_3to2 #(.WIDTH(W)) u_csa_ab (
    .x     (s_q),
    .y     (c_q),
    .z     (addend_b),
    .sum   (s1),
    .carry (c1)
  );

  csa_3to2 #(.WIDTH(W + 1)) u_csa_qn (
    .x     ({1'b0, s1}),
    .y     (c1),
    .z     (addend_n),
    .sum   (s2),
    .carry (c2)
  );

  // Bits dropped by the exact halving and the top guard bits, which the
  // result bound keeps at zero.
  assign unused_bits = ^{s2[0], c2[0], c2[W+1], s_next[W-1], c_next[W-1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // Next-state logic.  A start outside IDLE is simply ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy                 = (state != IDLE);
    start_final_addition = (state == DONE);
  end

  // Operand latch, accumulators and iteration counter.  Starting clears the
  // accumulators; each RUN cycle performs one iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      s_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            n_q <= n;
            s_q <= '0;
            c_q <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          s_q <= s_next;
          c_q <= c_next;
          cnt <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MONT_OUT_REG_EN
  logic [DATA_WIDTH:0] out_s_q;
  logic [DATA_WIDTH:0] out_c_q;

  // Result registers capture the final iteration as it is computed, so they
  // carry the new result at the same time the FSM enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_s_q <= '0;
      out_c_q <= '0;
    end else if (ce && (state == RUN) && last_iter) begin
      out_s_q <= s_next[W-2:0];
      out_c_q <= c_next[W-2:0];
    end
  end

  assign s0_r = out_s_q;
  assign s1_r = out_c_q;
`else
  // Direct views of the accumulators; the top guard bit is always zero.
  assign s0_r = s_q[W-2:0];
  assign s1_r = c_q[W-2:0];
`endif

endmodule

// File: tb/tb_mont_csa_multiplier.sv
// ---------------------------------------------------------------------------
// tb_mont_csa_multiplier
// Self-checking bench for mont_csa_multiplier with DATA_WIDTH=6.  A table of
// hand-computed vectors is run through the multiplier, followed by
// hand-written sequences for clock-enable stalls, ignored starts, reset abort
// and (when MONT_OUT_REG_EN is defined) output holding.
// ---------------------------------------------------------------------------
module tb_mont_csa_multiplier;

  localparam int DW = 6;

  logic          clk;
  logic          rst;
  logic          ce;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] n;
  logic          busy;
  logic [DW:0]   s0_r;
  logic [DW:0]   s1_r;
  logic          start_final_addition;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int n;
    int r;
    bit exact0;
  } vec_t;

  vec_t vecs[8];

  mont_csa_multiplier #(.DATA_WIDTH(DW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ce                   (ce),
    .start                (start),
    .a                    (a),
    .b                    (b),
    .n                    (n),
    .busy                 (busy),
    .s0_r                 (s0_r),
    .s1_r                 (s1_r),
    .start_final_addition (start_final_addition)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // The redundant result is correct if its sum is r or r+N.
  task automatic checkResult(input string name, input int r, input int nmod);
    int sum;
    sum = int'(s0_r) + int'(s1_r);
    checks++;
    if (sum != r && sum != r + nmod) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d or %0d", name, sum, r, r + nmod);
    end
  endtask

  // Advance one clock and sample shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high for one edge (edge 0).
  task automatic applyStimulus(input int va, input int vb, input int vn);
    a     = DW'(va);
    b     = DW'(vb);
    n     = DW'(vn);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
  endtask

  // Count edges until the completion pulse appears; bounded wait.
  task automatic waitPulse(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      if (start_final_addition) break;
    end
    if (!start_final_addition) begin
      errors++;
      checks++;
      $display("[TB] FAIL pulse_timeout actual=0 required=1");
    end
  endtask

  // One complete multiplication from the table.
  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v.a, v.b, v.n);
    waitPulse(lat);
    checkOutput("latency", lat, DW);
    checkResult("result", v.r, v.n);
    if (v.exact0) begin
      checkOutput("zero_s0", int'(s0_r), 0);
      checkOutput("zero_s1", int'(s1_r), 0);
    end
    tick();
    checkOutput("pulse_drop", int'(start_final_addition), 0);
    checkOutput("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int lat;
    int pulses;
    int held_s0;
    int held_s1;
    int cnt_edges;

    // Expected values: R = 64; for N = 53, 64^-1 mod 53 = 29.
    vecs[0] = '{a: 10, b: 20, n: 53, r: 23, exact0: 1'b0};
    vecs[1] = '{a: 1,  b: 1,  n: 53, r: 29, exact0: 1'b0};
    vecs[2] = '{a: 0,  b: 45, n: 53, r: 0,  exact0: 1'b1};
    vecs[3] = '{a: 45, b: 0,  n: 53, r: 0,  exact0: 1'b1};
    vecs[4] = '{a: 52, b: 52, n: 53, r: 29, exact0: 1'b0};
    vecs[5] = '{a: 2,  b: 3,  n: 53, r: 15, exact0: 1'b0};
    vecs[6] = '{a: 62, b: 62, n: 63, r: 1,  exact0: 1'b0};
    vecs[7] = '{a: 2,  b: 2,  n: 3,  r: 1,  exact0: 1'b0};

    rst   = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    n     = '0;

    // Reset state.
    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_s0", int'(s0_r), 0);
    checkOutput("reset_s1", int'(s1_r), 0);
    checkOutput("reset_pulse", int'(start_final_addition), 0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i]);
    end

    // Clock enable low for three cycles during RUN delays the pulse to edge 9.
    applyStimulus(10, 20, 53);
    tick();
    tick();
    held_s0 = int'(s0_r);
    held_s1 = int'(s1_r);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_busy", int'(busy), 1);
      checkOutput("stall_s0", int'(s0_r), held_s0);
      checkOutput("stall_s1", int'(s1_r), held_s1);
    end
    ce = 1'b1;
    waitPulse(lat);
    checkOutput("stall_latency", lat + 5, 9);
    checkResult("stall_result", 23, 53);
    // Pulse stretches while ce is low.
    ce = 1'b0;
    tick();
    tick();
    checkOutput("stretch_pulse", int'(start_final_addition), 1);
    ce = 1'b1;
    tick();
    checkOutput("stretch_drop", int'(start_final_addition), 0);
    checkOutput("stretch_busy", int'(busy), 0);

    // Start held high through RUN and DONE with a different A is ignored.
    applyStimulus(10, 20, 53);
    a      = 6'd1;
    b      = 6'd1;
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (start_final_addition) begin
        pulses++;
        checkResult("restart_result", 23, 53);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start_final_addition) pulses++;
    end
    checkOutput("restart_pulses", pulses, 1);
    checkOutput("restart_busy", int'(busy), 0);

    // Reset during iteration 3 aborts without a pulse.
    applyStimulus(10, 20, 53);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_s0", int'(s0_r), 0);
    checkOutput("abort_s1", int'(s1_r), 0);
    checkOutput("abort_pulse", int'(start_final_addition), 0);
    tick();
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_final_addition) pulses++;
    end
    checkOutput("abort_no_pulse", pulses, 0);
    runVector(vecs[0]);

`ifdef MONT_OUT_REG_EN
    // Previous result is held until the next one completes.
    applyStimulus(1, 1, 53);
    cnt_edges = 0;
    for (int i = 0; i < 20; i++) begin
      if (start_final_addition) break;
      checkResult("hold_result", 23, 53);
      tick();
      cnt_edges++;
    end
    checkOutput("hold_latency", cnt_edges, DW);
    checkResult("new_result", 29, 53);
`else
    cnt_edges = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
